// File: rtl/rs_fifo_drain_pkg.sv
// Shared types and helpers for the FIFO drain stage and its two-entry output buffer.
package rs_fifo_drain_pkg;

  localparam int W     = 11;
  localparam int OCC_W = 2;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } entry_t;

  function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                input logic push,
                                                input logic pop);
    logic [OCC_W-1:0] nxt;
    case ({push, pop})
      2'b10:   nxt = occ + 2'd1;
      2'b01:   nxt = occ - 2'd1;
      default: nxt = occ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rs_skid_buf2.sv
// Two-entry, order-preserving valid/ready buffer; head is always the oldest entry.
module rs_skid_buf2
  import rs_fifo_drain_pkg::*;
#(
  parameter int EW = $bits(entry_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [EW-1:0]    push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [EW-1:0]    head
);

  logic [EW-1:0]    e0_q, e0_d;
  logic [EW-1:0]    e1_q, e1_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Next-state for the two slots; e0 is the head, e1 only ever holds the younger word.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_step(occ_q, push, pop);
    case ({push, pop})
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_d = push_data;
        end else begin
          e1_d = push_data;
        end
      end
      2'b01:   e0_d = e1_q;
      default: e0_d = e0_q;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= {EW{1'b0}};
      e1_q  <= {EW{1'b0}};
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/rs_fifo_drain_stream.sv
// Drains a sync FIFO into a valid/ready stream, tagging the last word of each frame.
module rs_fifo_drain_stream
  import rs_fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_restart,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);

  logic [OCC_W-1:0]     occ_s;
  logic [DATA_WIDTH:0]  head_s;
  logic                 pop_s;
  logic                 cap_last_s;
  logic [FRM_W-1:0]     frm_base_s;
  logic                 rd_q, rd_d;
  logic [FRM_W-1:0]     frm_cnt_q, frm_cnt_d;
  logic [CNT_WIDTH-1:0] words_out_q, words_out_d;

  // fifo_empty lags the FIFO count, so a read in the previous cycle blocks this one.
  assign fifo_read_en = enable & ~fifo_empty & ~rd_q & (occ_s < 2'd2);
  assign m_valid      = (occ_s != 2'd0);
  assign pop_s        = m_valid & m_ready;

  // Frame position of the word being captured and the counter's next value.
  always_comb begin
    rd_d        = fifo_read_en;
    frm_base_s  = frame_restart ? {FRM_W{1'b0}} : frm_cnt_q;
    cap_last_s  = (frm_base_s == FRM_LAST);
    if (fifo_read_en) begin
      frm_cnt_d = cap_last_s ? {FRM_W{1'b0}} : frm_base_s + FRM_W'(1);
    end else begin
      frm_cnt_d = frm_base_s;
    end
    if (pop_s) begin
      words_out_d = words_out_q + CNT_WIDTH'(1);
    end else begin
      words_out_d = words_out_q;
    end
  end

  // Read-issue history, frame position and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= 1'b0;
      frm_cnt_q   <= {FRM_W{1'b0}};
      words_out_q <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_q        <= rd_d;
      frm_cnt_q   <= frm_cnt_d;
      words_out_q <= words_out_d;
    end
  end

  rs_skid_buf2 #(
    .EW (DATA_WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_read_en),
    .push_data ({cap_last_s, fifo_data_out}),
    .pop       (pop_s),
    .occ       (occ_s),
    .head      (head_s)
  );

  assign m_last    = head_s[DATA_WIDTH];
  assign m_data    = head_s[DATA_WIDTH-1:0];
  assign words_out = words_out_q;

endmodule

// File: tb/tb_rs_fifo_drain_stream.sv
// Bench for rs_fifo_drain_stream: lagging-empty FIFO environment, queue-based stream model,
// directed scenarios with literal expectations and a randomized soak.
module tb_rs_fifo_drain_stream;

  localparam int DW = 11;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_restart = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_read_en, fifo_read_en1;
  logic          m_valid, m_valid1, m_last, m_last1;
  logic [DW-1:0] m_data, m_data1;
  logic [15:0]   words_out, words_out1;

  always #5 clk = ~clk;

  rs_fifo_drain_stream dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_restart(frame_restart),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_read_en(fifo_read_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .words_out(words_out)
  );

  rs_fifo_drain_stream #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_restart(frame_restart),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_read_en(fifo_read_en1),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
    .words_out(words_out1)
  );

  // FIFO environment: empty flag reflects the previous cycle's count.
  logic [DW-1:0] mem [0:255];
  logic [8:0]    wr_ptr, rd_ptr;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] src_q[$];

  assign fifo_data_out = mem[rd_ptr[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 9'd0;
      rd_ptr     <= 9'd0;
      fifo_empty <= 1'b1;
    end else begin
      fifo_empty <= (wr_ptr == rd_ptr);
      if (fifo_read_en) rd_ptr <= rd_ptr + 9'd1;
      if (wr_req) begin
        mem[wr_ptr[7:0]] <= wr_data;
        wr_ptr <= wr_ptr + 9'd1;
        src_q.push_back(wr_data);
      end
    end
  end

  // Behavioural model state
  logic [DW:0] exp_q[$];
  logic [DW:0] log_q[$];
  int          pos = 0;
  bit          prev_rd = 1'b0;
  logic [15:0] words_exp = 16'd0;
  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;

  always @(negedge clk) begin
    bit          m_rd;
    bit          exp_v;
    logic [DW:0] hd;
    int          base;
    if (!rst_n) begin
      exp_q.delete();
      src_q.delete();
      pos = 0;
      prev_rd = 1'b0;
      words_exp = 16'd0;
      checks++;
      if (fifo_read_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 ||
          words_out !== 16'd0 || m_valid1 !== 1'b0 || words_out1 !== 16'd0) begin
        failures++;
        $display("FAIL reset_state rd=%b valid=%b data=%h last=%b words=%0d (required all zero)",
                 fifo_read_en, m_valid, m_data, m_last, words_out);
      end
    end else begin
      exp_v = (exp_q.size() != 0);
      hd    = exp_v ? exp_q[0] : '0;
      m_rd  = enable && !fifo_empty && !prev_rd && (exp_q.size() < 2);
      checks++;
      if (fifo_read_en !== m_rd) begin
        failures++;
        $display("FAIL read_en t=%0t actual=%b required=%b", $time, fifo_read_en, m_rd);
      end
      checks++;
      if (m_valid !== exp_v || (exp_v && {m_last, m_data} !== hd)) begin
        failures++;
        $display("FAIL stream t=%0t actual valid=%b last=%b data=%h required valid=%b last=%b data=%h",
                 $time, m_valid, m_last, m_data, exp_v, hd[DW], hd[DW-1:0]);
      end
      checks++;
      if (words_out !== words_exp) begin
        failures++;
        $display("FAIL words_out t=%0t actual=%0d required=%0d", $time, words_out, words_exp);
      end
      checks++;
      if (fifo_read_en1 !== m_rd || m_valid1 !== exp_v || words_out1 !== words_exp ||
          (exp_v && (m_data1 !== hd[DW-1:0] || m_last1 !== 1'b1))) begin
        failures++;
        $display("FAIL frame_len1 t=%0t actual valid=%b last=%b data=%h required valid=%b last=1 data=%h",
                 $time, m_valid1, m_last1, m_data1, exp_v, hd[DW-1:0]);
      end
      checks++;
      if (fifo_read_en && (wr_ptr == rd_ptr)) begin
        failures++;
        $display("FAIL underflow t=%0t actual=read_of_empty_fifo required=no_read", $time);
      end
      if (fifo_read_en) rd_cnt++;
      if (m_valid && m_ready) log_q.push_back({m_last, m_data});
      if (exp_v && m_ready) begin
        void'(exp_q.pop_front());
        words_exp = words_exp + 16'd1;
      end
      if (m_rd) begin
        base = frame_restart ? 0 : pos;
        if (src_q.size() == 0) begin
          failures++;
          $display("FAIL model_src t=%0t actual=empty required=word_available", $time);
        end else begin
          exp_q.push_back({(base == FL - 1), src_q.pop_front()});
        end
        pos = (base + 1) % FL;
      end else if (frame_restart) begin
        pos = 0;
      end
      prev_rd = m_rd;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    tick(1);
    wr_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Compares the logged handshakes against data base+i and a last-flag bit vector.
  task automatic chk_log(input string nm, input int n, input int base, input logic [7:0] lasts);
    logic [DW:0] req;
    chk({nm, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      req = {lasts[i], DW'(base + i)};
      if (i < log_q.size()) chk({nm, "_word"}, 32'(log_q[i]), 32'(req));
    end
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: eight preloaded words, consumer always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    tick(3);
    log_q.delete();
    enable = 1'b1;
    tick(30);
    chk_log("t1_log", 8, 1, 8'b1000_1000);
    chk("t1_words_out", 32'(words_out), 32'd8);

    // 2: consumer stalled with five words queued
    do_reset();
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(DW'(i));
    tick(2);
    log_q.delete();
    rd_cnt = 0;
    enable = 1'b1;
    tick(20);
    chk("t2_reads", 32'(rd_cnt), 32'd2);
    chk("t2_hold_data", 32'(m_data), 32'h001);
    chk("t2_hold_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick(30);
    chk_log("t2_log", 5, 1, 8'b0000_1000);

    // 3: single word, lagging empty must not cause a second read
    tick(5);
    rd_cnt = 0;
    wr(11'h0AA);
    tick(10);
    chk("t3_reads", 32'(rd_cnt), 32'd1);

    // 4: pause reads after word 2 of a frame, then resume
    do_reset();
    log_q.delete();
    rd_cnt  = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    wr(11'd1);
    wr(11'd2);
    for (int k = 0; k < 20 && rd_cnt < 2; k++) tick(1);
    chk("t4_first_reads", 32'(rd_cnt), 32'd2);
    enable = 1'b0;
    for (int i = 3; i <= 5; i++) wr(DW'(i));
    tick(5);
    enable = 1'b1;
    tick(20);
    chk_log("t4_log", 5, 1, 8'b0000_1000);

    // 5: frame_restart coincident with capture of word 2
    do_reset();
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) wr(DW'(11'h011 + i));
    tick(3);
    log_q.delete();
    rd_cnt = 0;
    enable = 1'b1;
    for (int k = 0; k < 40 && !(rd_cnt == 1 && fifo_read_en); k++) tick(1);
    chk("t5_restart_aligned", 32'(rd_cnt == 1 && fifo_read_en), 32'd1);
    frame_restart = 1'b1;
    tick(1);
    frame_restart = 1'b0;
    tick(20);
    chk_log("t5_log", 5, 32'h011, 8'b0001_0000);

    // 6: reset while the buffer is full mid-frame
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    wr(11'd1);
    wr(11'd2);
    tick(10);
    m_ready = 1'b0;
    for (int i = 3; i <= 7; i++) wr(DW'(i));
    tick(12);
    chk("t6_pre_words", 32'(words_out), 32'd2);
    chk("t6_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_cleared", 32'(m_valid), 32'd0);
    chk("t6_words_cleared", 32'(words_out), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    log_q.delete();
    m_ready = 1'b1;
    wr(11'h3FF);
    tick(8);
    chk_log("t6_log", 1, 32'h3FF, 8'b0000_0000);

    // Randomized soak with one mid-run reset
    for (int c = 0; c < 2500; c++) begin
      enable        = ($urandom_range(9) < 8);
      m_ready       = ($urandom_range(9) < 7);
      frame_restart = ($urandom_range(19) == 0);
      wr_req        = ($urandom_range(9) < 4) && ((wr_ptr - rd_ptr) < 9'd200);
      wr_data       = DW'($urandom);
      rst_n         = !(c == 1200 || c == 1201);
      tick(1);
    end
    wr_req        = 1'b0;
    frame_restart = 1'b0;
    enable        = 1'b1;
    m_ready       = 1'b1;
    rst_n         = 1'b1;
    tick(600);
    chk("final_drained", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
